// File: rtl/input_conditioner.sv
// Synchronises and debounces the board switches and push-buttons, and packs them
// with sticky key-press flags into the 16-bit input word read by the core on SYNC.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  SW,
  input  logic [1:0]  KEY,
  input  logic        ack,
  output logic [15:0] inputs,
  output logic        changed
);

  localparam int unsigned NUM_BITS = 12;
  localparam int unsigned CNT_W    = 20;
  localparam int unsigned KEY_W    = 2;

  // KEY is active-low, so its idle (released) value is 1.
  localparam logic [NUM_BITS-1:0] RAW_RST = NUM_BITS'(12'h003);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BITS-1:0]            raw;
  logic [NUM_BITS-1:0]            sync1;
  logic [NUM_BITS-1:0]            sync2;
  logic [NUM_BITS-1:0]            stable;
  logic [NUM_BITS-1:0]            stable_nxt;
  logic [NUM_BITS-1:0][CNT_W-1:0] cnt;
  logic [NUM_BITS-1:0][CNT_W-1:0] cnt_nxt;
  logic [KEY_W-1:0]               sticky;
  logic [KEY_W-1:0]               sticky_nxt;
  logic [KEY_W-1:0]               press;
  logic                           changed_nxt;

  assign raw = {SW, KEY};

  // Per-bit debounce counters, press detection and sticky-flag update.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int unsigned i = 0; i < NUM_BITS; i++) begin
      if (sync2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = sync2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
    // A falling stable KEY bit is a press; set takes priority over ack.
    press       = stable[KEY_W-1:0] & ~stable_nxt[KEY_W-1:0];
    sticky_nxt  = press | (sticky & {KEY_W{~ack}});
    changed_nxt = |(stable ^ stable_nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= RAW_RST;
      sync2   <= RAW_RST;
      stable  <= RAW_RST;
      cnt     <= '0;
      sticky  <= '0;
      changed <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      stable  <= stable_nxt;
      cnt     <= cnt_nxt;
      sticky  <= sticky_nxt;
      changed <= changed_nxt;
    end
  end

  assign inputs = {2'b00, sticky, stable};

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: cycle-by-cycle vector table on a
// DEBOUNCE_CYCLES=4 instance plus a reset-mid-count sequence on a =8 instance.
module tb_input_conditioner;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  SW;
  logic [1:0]  KEY;
  logic        ack;
  logic [15:0] inputs;
  logic        changed;

  logic        reset8;
  logic [9:0]  sw8;
  logic [1:0]  key8;
  logic        ack8;
  logic [15:0] inputs8;
  logic        changed8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [9:0]  sw;
    logic [1:0]  key;
    logic        ack;
    logic [15:0] exp_in;
    logic        exp_ch;
  } vec_t;

  typedef struct {
    string       name;
    logic        sel;
    logic [15:0] exp_in;
    logic        exp_ch;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clock   (clock),
    .reset   (reset),
    .SW      (SW),
    .KEY     (KEY),
    .ack     (ack),
    .inputs  (inputs),
    .changed (changed)
  );

  input_conditioner #(.DEBOUNCE_CYCLES(8)) dut8 (
    .clock   (clock),
    .reset   (reset8),
    .SW      (sw8),
    .KEY     (key8),
    .ack     (ack8),
    .inputs  (inputs8),
    .changed (changed8)
  );

  always #5 clock = ~clock;

  task automatic add(input int n, input logic r, input logic [9:0] s, input logic [1:0] k,
                     input logic a, input logic [15:0] ei, input logic ec);
    vec_t v;
    v.rst = r; v.sw = s; v.key = k; v.ack = a; v.exp_in = ei; v.exp_ch = ec;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic push_exp(input string name, input logic sel, input logic [15:0] ei, input logic ec);
    exp_t e;
    e.name = name; e.sel = sel; e.exp_in = ei; e.exp_ch = ec;
    sb.push_back(e);
  endtask

  task automatic check_one();
    exp_t        e;
    logic [15:0] ai;
    logic        ac;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
      return;
    end
    e  = sb.pop_front();
    ai = e.sel ? inputs8 : inputs;
    ac = e.sel ? changed8 : changed;
    if (ai !== e.exp_in || ac !== e.exp_ch) begin
      errors++;
      $display("FAIL %s: got inputs=%h changed=%b, required inputs=%h changed=%b",
               e.name, ai, ac, e.exp_in, e.exp_ch);
    end
  endtask

  initial begin
    reset = 1'b1; SW = '0; KEY = 2'b11; ack = 1'b0;
    reset8 = 1'b1; sw8 = '0; key8 = 2'b11; ack8 = 1'b0;

    // Reset with random raw inputs, then first cycle after deassert.
    add(1, 1'b1, 10'($urandom), 2'($urandom), 1'b0, 16'h0003, 1'b0);
    add(1, 1'b1, 10'($urandom), 2'($urandom), 1'b0, 16'h0003, 1'b0);
    add(1, 1'b1, 10'($urandom), 2'($urandom), 1'b0, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);
    // Clean all-switch change up and back down: flips after edge 1+D.
    add(5, 1'b0, 10'h3FF, 2'b11, 1'b0, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h3FF, 2'b11, 1'b0, 16'h0FFF, 1'b1);
    add(3, 1'b0, 10'h3FF, 2'b11, 1'b0, 16'h0FFF, 1'b0);
    add(5, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0FFF, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b1);
    add(2, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);
    // 3-cycle glitch is rejected.
    add(3, 1'b0, 10'h001, 2'b11, 1'b0, 16'h0003, 1'b0);
    add(6, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);
    // 4-cycle pulse is accepted, then debounced back down.
    add(4, 1'b0, 10'h001, 2'b11, 1'b0, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0007, 1'b1);
    add(3, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0007, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b1);
    add(2, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);
    // KEY0 press held 10 cycles: sticky flag survives release until ack.
    add(5, 1'b0, 10'h000, 2'b10, 1'b0, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h000, 2'b10, 1'b0, 16'h1002, 1'b1);
    add(4, 1'b0, 10'h000, 2'b10, 1'b0, 16'h1002, 1'b0);
    add(5, 1'b0, 10'h000, 2'b11, 1'b0, 16'h1002, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h1003, 1'b1);
    add(2, 1'b0, 10'h000, 2'b11, 1'b0, 16'h1003, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b1, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);
    // KEY1 press coinciding with ack: set wins.
    add(5, 1'b0, 10'h000, 2'b01, 1'b0, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h000, 2'b01, 1'b1, 16'h2001, 1'b1);
    add(2, 1'b0, 10'h000, 2'b01, 1'b0, 16'h2001, 1'b0);
    add(5, 1'b0, 10'h000, 2'b11, 1'b0, 16'h2001, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h2003, 1'b1);
    add(1, 1'b0, 10'h000, 2'b11, 1'b1, 16'h0003, 1'b0);
    // Fast toggling never reaches the stable value.
    for (int t = 0; t < 8; t++) begin
      add(2, 1'b0, 10'h200, 2'b11, 1'b0, 16'h0003, 1'b0);
      add(2, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);
    end
    add(3, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);
    // Reset from a non-idle state.
    add(1, 1'b0, 10'h155, 2'b10, 1'b0, 16'h0003, 1'b0);
    add(4, 1'b0, 10'h155, 2'b10, 1'b0, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h155, 2'b10, 1'b0, 16'h1556, 1'b1);
    add(1, 1'b1, 10'h155, 2'b10, 1'b0, 16'h0003, 1'b0);
    add(1, 1'b0, 10'h000, 2'b11, 1'b0, 16'h0003, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset = vecs[i].rst;
      SW    = vecs[i].sw;
      KEY   = vecs[i].key;
      ack   = vecs[i].ack;
      push_exp($sformatf("vec%0d", i), 1'b0, vecs[i].exp_in, vecs[i].exp_ch);
      @(posedge clock);
      #1;
      check_one();
    end

    // Reset mid-count on the D=8 instance: earlier count earns no credit.
    @(negedge clock);
    reset8 = 1'b0;
    for (int k = -2; k < 20; k++) begin
      if (k >= 0) begin
        @(negedge clock);
      end
      sw8    = (k >= 0) ? 10'h020 : 10'h000;
      reset8 = (k == 7);
      if (k < 17) push_exp($sformatf("rstmid_k%0d", k), 1'b1, 16'h0003, 1'b0);
      else if (k == 17) push_exp($sformatf("rstmid_k%0d", k), 1'b1, 16'h0083, 1'b1);
      else push_exp($sformatf("rstmid_k%0d", k), 1'b1, 16'h0083, 1'b0);
      @(posedge clock);
      #1;
      check_one();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronises and debounces the board switches and push-buttons and presents them as one packed 16-bit input word to the stack-machine core. The core latches this word into RAM at `INPUT_BEGIN` when it executes `SYNC`. The block sits directly upstream of the core's `SYNC` path and replaces raw `SW`/`KEY` wiring. It also provides sticky key-press flags so that short presses between two `SYNC` instructions are not lost.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive cycles a synchronised input must disagree with its stable value before the stable value flips. Legal range 1..1048575. The counter is 20 bits wide.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `SW`  in  10  raw slide switches, asynchronous.
- `KEY`  in  2  raw push-buttons, asynchronous, active-low (0 = pressed).
- `ack`  in  1  one-cycle pulse from the core when the word has been consumed; clears the sticky press flags.
- `inputs`  out  16  packed word, laid out as follows:
  - [15:14] = 0
  - [13:12] = sticky press flags for KEY1, KEY0
  - [11:2] = stable `SW[9:0]`
  - [1:0] = stable `KEY[1:0]`, active-low
- `changed`  out  1  one-cycle pulse when any stable bit flips.

## Operation
- **Synchronisation.** Each of the 12 raw bits passes through two flops, `sync1` then `sync2`.
- **Debounce.** Each bit has an independent counter `cnt[i]`.
  - If `sync2[i] == stable[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i]` <= `sync2[i]` and `cnt[i]` <= 0.
  - Else: `cnt[i]` <= `cnt[i]+1`.
  - A disagreement shorter than `DEBOUNCE_CYCLES` cycles produces no output change, and the counter restarts from 0 on the next disagreement.
- **Press detection.** A stable KEY bit changing 1->0 sets the matching sticky flag. A 0->1 change (release) never sets or clears a flag.
- **Sticky clear.** `ack` clears both flags. If a press event and `ack` occur in the same cycle, set wins and the flag remains 1.
- **`changed`.** Registered OR of all stable-bit flips in that cycle, high for exactly one cycle per flip event.
- **Output register.** `inputs` is driven from registers only; it has no combinational path from `SW`, `KEY` or `ack`.
- **Reset values.** `reset` has priority over all other logic:
  - `sync1`/`sync2` for SW = 0, for KEY = 1.
  - Stable SW = 0, stable KEY = 2'b11.
  - All counters = 0.
  - Sticky flags = 0.
  - `changed` = 0.
  - `inputs` = 16'h0003.
- **Reset mid-debounce.** A reset asserted while a count is in progress discards the count. After reset deasserts, a held input must disagree for a full `DEBOUNCE_CYCLES` again.

## Timing
- **Latency.** A raw change captured by `sync1` at edge t, and held, appears on `inputs` after edge t+1+`DEBOUNCE_CYCLES`. `changed` is high during the following cycle.
- **Sticky flag timing.** The flag sets on the same edge that the stable KEY bit falls.
- **`ack` timing.** `ack` sampled at edge t clears the flags, so they read 0 after edge t.
- **Independent bits.** Bits debounce independently. Two bits whose raw values change on the same cycle flip on the same edge, and `changed` is a single one-cycle pulse.
- **Counter range.** The counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- **Steady state.** A raw input toggling faster than every `DEBOUNCE_CYCLES` cycles holds the stable value indefinitely.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 unless stated otherwise.
- **Reset.** Assert `reset` for 3 cycles with random `SW`/`KEY` -> `inputs`=16'h0003 and `changed`=0 throughout and on the first cycle after deassert.
- **Clean switch change.** Set `SW`=10'h3FF at edge 0 and hold -> `inputs`=16'h0FFF after edge 5 (1+D) and not before; `changed`=1 for exactly one cycle.
- **Glitch rejection.** Pulse `SW[0]`=1 for 3 cycles, then 0 -> `inputs` stays 16'h0003 and `changed` never asserts. Repeat with a 4-cycle pulse -> bit 2 sets.
- **Key press and sticky flag.** Hold `KEY[0]`=0 for 10 cycles, then release -> `inputs`[0] goes 0 then back to 1, and `inputs`[12] sets to 1 and stays 1 after the release. Then pulse `ack` -> `inputs`[12]=0 on the next cycle.
- **Simultaneous set and ack.** Time `ack` to coincide with the edge where stable `KEY[1]` falls -> `inputs`[13]=1 after that edge.
- **Reset mid-count.** With `DEBOUNCE_CYCLES`=8, hold `SW[5]`=1, assert `reset` at count 5 for one cycle, then deassert -> bit 7 sets exactly 1+8 edges after `sync1` recaptures the input following reset (no credit for the earlier 5 cycles).
